// File: rtl/serial_word_adder_if.sv
// serial_word_adder_if: operand/result handshake bundle; up_sub exists only with SERIAL_WORD_ADDER_SUB_EN.
interface serial_word_adder_if #(parameter int WIDTH = 8);
  logic             up_valid;
  logic             up_ready;
  logic [WIDTH-1:0] up_a;
  logic [WIDTH-1:0] up_b;
`ifdef SERIAL_WORD_ADDER_SUB_EN
  logic             up_sub;
`endif
  logic             down_valid;
  logic             down_ready;
  logic [WIDTH-1:0] down_sum;
  logic             down_carry;
  modport master (
`ifdef SERIAL_WORD_ADDER_SUB_EN
    output up_sub,
`endif
    output up_valid, up_a, up_b, down_ready,
    input  up_ready, down_valid, down_sum, down_carry
  );
  modport slave (
`ifdef SERIAL_WORD_ADDER_SUB_EN
    input  up_sub,
`endif
    input  up_valid, up_a, up_b, down_ready,
    output up_ready, down_valid, down_sum, down_carry
  );
endinterface

// File: rtl/serial_word_adder.sv
// serial_word_adder: word handshake front end around a 1-bit serial full adder, LSB first.
// SERIAL_WORD_ADDER_SUB_EN adds up_sub for two's-complement A-B.
module serial_word_adder #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  serial_word_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_b_load;
  logic             w_c_init;
  logic             w_s;
  logic             w_c;
  logic             w_last;
`ifdef SERIAL_WORD_ADDER_SUB_EN
  assign w_b_load = bus.up_sub ? ~bus.up_b : bus.up_b;
  assign w_c_init = bus.up_sub;
`else
  assign w_b_load = bus.up_b;
  assign w_c_init = 1'b0;
`endif
  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_last = r_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_comb begin
    w_next = (r_state == IDLE)  ? (bus.up_valid ? SHIFT : IDLE) :
             (r_state == SHIFT) ? (w_last ? DONE : SHIFT) :
                                  (bus.down_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.up_ready   = r_state == IDLE;
    bus.down_valid = r_state == DONE;
    bus.down_sum   = r_sum;
    bus.down_carry = r_carry;
  end
  // sum bits enter at the MSB so bit i reaches position i after WIDTH steps
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == IDLE && bus.up_valid) begin
      r_a     <= bus.up_a;
      r_b     <= w_b_load;
      r_carry <= w_c_init;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_sum   <= {w_s, r_sum[WIDTH-1:1]};
      r_a     <= {1'b0, r_a[WIDTH-1:1]};
      r_b     <= {1'b0, r_b[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_serial_word_adder.sv
// tb_serial_word_adder: directed checks of add, carry clearing, backpressure, reset, back-to-back and subtract.
module tb_serial_word_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  serial_word_adder_if #(.WIDTH(8)) bus ();
  serial_word_adder #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                       output logic [7:0] sum, output logic carry, output int lat);
    bus.up_a = a;
    bus.up_b = b;
`ifdef SERIAL_WORD_ADDER_SUB_EN
    bus.up_sub = sub;
`else
    if (sub) $display("note: subtract requested without SERIAL_WORD_ADDER_SUB_EN");
`endif
    bus.up_valid = 1'b1;
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    lat = 0;
    while (!bus.down_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    sum = bus.down_sum;
    carry = bus.down_carry;
  endtask

  task automatic release_result();
    bus.down_ready = 1'b1;
    @(posedge clk); #1;
    bus.down_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (bus.up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_up_ready got %b want 1", bus.up_ready); end
    if (bus.down_valid !== 1'b0) begin n_fail++; $display("FAIL reset_down_valid got %b want 0", bus.down_valid); end
    if (bus.down_sum !== 8'h00) begin n_fail++; $display("FAIL reset_down_sum got %h want 00", bus.down_sum); end
    if (bus.down_carry !== 1'b0) begin n_fail++; $display("FAIL reset_down_carry got %b want 0", bus.down_carry); end
  endtask

  task automatic test_add(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic sub, input logic [7:0] exp_s, input logic exp_c);
    logic [7:0] s;
    logic       c;
    int         lat;
    do_op(a, b, sub, s, c, lat);
    n_checks += 4;
    if (lat !== 8) begin n_fail++; $display("FAIL %s_latency got %0d want 8", name, lat); end
    if (s !== exp_s) begin n_fail++; $display("FAIL %s_sum got %h want %h", name, s, exp_s); end
    if (c !== exp_c) begin n_fail++; $display("FAIL %s_carry got %b want %b", name, c, exp_c); end
    release_result();
    if (bus.up_ready !== 1'b1) begin n_fail++; $display("FAIL %s_idle got up_ready %b want 1", name, bus.up_ready); end
  endtask

  task automatic test_backpressure();
    logic [7:0] s;
    logic       c;
    int         lat;
    do_op(8'h5A, 8'h3C, 1'b0, s, c, lat);
    bus.up_a = 8'hAA;
    bus.up_b = 8'h55;
    bus.up_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks += 4;
      if (bus.down_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.down_valid); end
      if (bus.up_ready !== 1'b0) begin n_fail++; $display("FAIL bp_up_ready[%0d] got %b want 0", i, bus.up_ready); end
      if (bus.down_sum !== 8'h96) begin n_fail++; $display("FAIL bp_sum[%0d] got %h want 96", i, bus.down_sum); end
      if (bus.down_carry !== 1'b0) begin n_fail++; $display("FAIL bp_carry[%0d] got %b want 0", i, bus.down_carry); end
      @(posedge clk); #1;
    end
    bus.up_valid = 1'b0;
    release_result();
    n_checks += 2;
    if (bus.up_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got %b want 1", bus.up_ready); end
    if (bus.down_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid got %b want 0", bus.down_valid); end
  endtask

  task automatic test_mid_reset();
    bus.up_a = 8'hF0;
    bus.up_b = 8'h0F;
    bus.up_valid = 1'b1;
    @(posedge clk); #1;
    bus.up_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks += 2;
    if (bus.up_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", bus.up_ready); end
    if (bus.down_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", bus.down_valid); end
    test_add("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] rs [2];
    logic       rc [2];
    int         acc_cyc [2];
    int         cyc = 0;
    int         n_acc = 0;
    int         n_res = 0;
    logic       acc;
    logic       res;
    bus.up_a = 8'h01;
    bus.up_b = 8'h01;
    bus.up_valid = 1'b1;
    bus.down_ready = 1'b1;
    while (n_res < 2 && cyc < 60) begin
      acc = bus.up_valid && bus.up_ready;
      res = bus.down_valid && bus.down_ready;
      if (res) begin rs[n_res] = bus.down_sum; rc[n_res] = bus.down_carry; end
      @(posedge clk); #1;
      cyc++;
      if (acc && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin bus.up_a = 8'h80; bus.up_b = 8'h80; end
        else bus.up_valid = 1'b0;
      end
      if (res) n_res++;
    end
    bus.up_valid = 1'b0;
    bus.down_ready = 1'b0;
    n_checks += 1;
    if (n_res !== 2 || n_acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_count got %0d results %0d accepts want 2 and 2", n_res, n_acc);
    end else begin
      n_checks += 5;
      if (rs[0] !== 8'h02) begin n_fail++; $display("FAIL b2b_sum0 got %h want 02", rs[0]); end
      if (rc[0] !== 1'b0) begin n_fail++; $display("FAIL b2b_carry0 got %b want 0", rc[0]); end
      if (rs[1] !== 8'h00) begin n_fail++; $display("FAIL b2b_sum1 got %h want 00", rs[1]); end
      if (rc[1] !== 1'b1) begin n_fail++; $display("FAIL b2b_carry1 got %b want 1", rc[1]); end
      if (acc_cyc[1] - acc_cyc[0] !== 10) begin
        n_fail++;
        $display("FAIL b2b_spacing got %0d want 10", acc_cyc[1] - acc_cyc[0]);
      end
    end
  endtask

  initial begin
    bus.up_valid = 1'b1;
    bus.up_a = 8'hFF;
    bus.up_b = 8'hFF;
`ifdef SERIAL_WORD_ADDER_SUB_EN
    bus.up_sub = 1'b0;
`endif
    bus.down_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    bus.up_valid = 1'b0;
    rst = 1'b0;
    test_add("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
    test_add("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    test_add("add_00_00", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    test_backpressure();
    test_mid_reset();
    test_back_to_back();
`ifdef SERIAL_WORD_ADDER_SUB_EN
    @(posedge clk); #1;
    test_add("sub_10_01", 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1);
    test_add("sub_01_02", 8'h01, 8'h02, 1'b1, 8'hFF, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
